// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO port arbiter slice.
// Holds the default data width, the sequencer state encoding and the
// {read,write} command encoding driven onto the FIFO control pins.
package fifo_pkg;

  localparam int WIDTH_DEF = 4;

  // Sequencer states: wait for work, hold a command until the FIFO
  // accepts it, then spend one cycle acknowledging.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Command word as {read, write}.
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_WR   = 2'b01,
    CMD_RD   = 2'b10,
    CMD_RW   = 2'b11
  } cmd_t;

  // Build a command word from independent read/write eligibility bits.
  function automatic cmd_t make_cmd(input logic rd, input logic wr);
    return cmd_t'({rd, wr});
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick.
// Ports:
//   req    - request bits from producer 0 (bit 0) and producer 1 (bit 1)
//   rr_ptr - producer favoured when both request
//   grant  - one-hot grant, or zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  // A lone requester always wins; a tie goes to whoever rr_ptr favours.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Sequencer/arbiter in front of a slow-strobed synchronous FIFO.
// Shares the FIFO write port between two producers (round-robin), schedules
// reads for one consumer, holds each command until the FIFO's accept strobe
// and returns one-cycle acknowledges.
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   tick                  - FIFO accept strobe (FIFO samples read/write here)
//   wr_req, wr_data0/1    - producer level requests and their data
//   wr_ack                - per-producer one-cycle write acknowledge
//   rd_req, rd_ack        - consumer level request and one-cycle acknowledge
//   fifo_read/write/in    - command pins driven to the FIFO
//   fifo_empty/full       - FIFO status flags
//   busy                  - command in flight (HOLD or SETTLE)
//   timeout_err           - sticky flag, set when a held command was aborted
module fifo_port_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = 32'd50000000,
  parameter int TO_BITS = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic [1:0]       wr_req,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic [WIDTH-1:0] wr_data1,
  output logic [1:0]       wr_ack,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic             fifo_read,
  output logic             fifo_write,
  output logic [WIDTH-1:0] fifo_in,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic             busy,
  output logic             timeout_err
);

  // Last counter value tolerated in HOLD before the command is abandoned.
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT - 1);

  state_t             state_q, state_d;
  cmd_t               cmd_q, cmd_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               winner_q, winner_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
  logic               to_err_q, to_err_d;
  logic [1:0]         wr_ack_q, wr_ack_d;
  logic               rd_ack_q, rd_ack_d;
  logic [1:0]         grant;
  logic               rd_ok, wr_ok;

  // Requests that would misuse the FIFO simply stay pending.
  assign rd_ok = rd_req & ~fifo_empty;
  assign wr_ok = (|wr_req) & ~fifo_full;

  rr_arb2 u_arb (
    .req    (wr_req),
    .rr_ptr (rr_ptr_q),
    .grant  (grant)
  );

  // Next-state logic. The timeout counter defaults to zero so it only
  // accumulates while a command waits in HOLD. Acks are produced on the
  // tick edge so they are visible during SETTLE, one cycle after tick.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    winner_d = winner_q;
    rr_ptr_d = rr_ptr_q;
    to_cnt_d = '0;
    to_err_d = to_err_q;
    wr_ack_d = 2'b00;
    rd_ack_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_ok | wr_ok) begin
          cmd_d    = make_cmd(rd_ok, wr_ok);
          data_d   = wr_ok ? (grant[1] ? wr_data1 : wr_data0) : '0;
          winner_d = grant[1];
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d  = SETTLE;
          cmd_d    = CMD_NONE;
          data_d   = '0;
          wr_ack_d = cmd_q[0] ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
          rd_ack_d = cmd_q[1];
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = IDLE;
          cmd_d    = CMD_NONE;
          data_d   = '0;
          to_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_BITS'(1);
        end
      end
      SETTLE: begin
        state_d = IDLE;
        if (wr_ack_q != 2'b00) begin
          rr_ptr_d = ~winner_q;
        end
      end
      default: begin
        state_d = IDLE;
        cmd_d   = CMD_NONE;
        data_d  = '0;
      end
    endcase
  end

  // State register; reset drops any in-flight command without acking it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_NONE;
      data_q   <= '0;
      winner_q <= 1'b0;
      rr_ptr_q <= 1'b0;
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
      wr_ack_q <= 2'b00;
      rd_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      winner_q <= winner_d;
      rr_ptr_q <= rr_ptr_d;
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
    end
  end

  assign fifo_read   = cmd_q[1];
  assign fifo_write  = cmd_q[0];
  assign fifo_in     = data_q;
  assign wr_ack      = wr_ack_q;
  assign rd_ack      = rd_ack_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Scoreboard bench for fifo_port_arbiter. Stimulus pushes the expected
// acknowledge/command record; the monitor pops one whenever an ack appears.
module tb_fifo_port_arbiter;

  logic       clock = 1'b0;
  logic       reset, tick, rd_req, fifo_empty, fifo_full;
  logic [1:0] wr_req;
  logic [3:0] wr_data0, wr_data1;
  logic [1:0] wr_ack;
  logic       rd_ack, fifo_read, fifo_write, busy, timeout_err;
  logic [3:0] fifo_in;

  int total = 0;
  int bad   = 0;

  // Record layout: [8:7] wr_ack, [6] rd_ack, [5] read, [4] write, [3:0] data
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;
  logic       cap_rd, cap_wr, prev_tick;
  logic [3:0] cap_in;

  fifo_port_arbiter #(.WIDTH(4), .TIMEOUT(8), .TO_BITS(26)) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .wr_req      (wr_req),
    .wr_data0    (wr_data0),
    .wr_data1    (wr_data1),
    .wr_ack      (wr_ack),
    .rd_req      (rd_req),
    .rd_ack      (rd_ack),
    .fifo_read   (fifo_read),
    .fifo_write  (fifo_write),
    .fifo_in     (fifo_in),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  function automatic logic [8:0] mk(input logic [1:0] wa, input logic ra,
                                    input logic r, input logic w,
                                    input logic [3:0] d);
    return {wa, ra, r, w, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Issue one request set from an IDLE cycle, verify the held command on
  // every HOLD cycle, tick on the last one, then return in the next IDLE.
  task automatic applyStimulus(input logic r, input logic [1:0] w,
                               input logic [3:0] d0, input logic [3:0] d1,
                               input int holdCycles, input logic [8:0] expVal,
                               input logic rel);
    exp_q.push_back(expVal);
    rd_req   = r;
    wr_req   = w;
    wr_data0 = d0;
    wr_data1 = d1;
    stepCycle();
    for (int i = 0; i < holdCycles; i++) begin
      checkOutput("hold_cmd", 32'({busy, fifo_read, fifo_write, fifo_in}),
                  32'({1'b1, expVal[5:0]}));
      if (i == holdCycles - 1) tick = 1'b1;
      stepCycle();
    end
    tick = 1'b0;
    if (rel) begin
      rd_req = 1'b0;
      wr_req = 2'b00;
    end
    stepCycle();
  endtask

  // Monitor: every ack must match the oldest expected record, carry the
  // command that was on the pins when tick hit, and arrive one cycle later.
  always @(negedge clock) begin
    if (wr_ack != 2'b00 || rd_ack) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_ack got wr_ack=%b rd_ack=%b want none",
                 wr_ack, rd_ack);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("ack_txn", 32'({wr_ack, rd_ack, cap_rd, cap_wr, cap_in}),
                    32'(mon_exp));
        checkOutput("ack_latency", 32'(prev_tick), 32'd1);
      end
    end
    prev_tick = tick && busy;
    if (tick && busy) begin
      cap_rd = fifo_read;
      cap_wr = fifo_write;
      cap_in = fifo_in;
    end
  end

  initial begin
    reset = 1'b1; tick = 1'b0; rd_req = 1'b0; wr_req = 2'b00;
    wr_data0 = 4'h0; wr_data1 = 4'h0; fifo_empty = 1'b1; fifo_full = 1'b0;
    cap_rd = 1'b0; cap_wr = 1'b0; cap_in = 4'h0; prev_tick = 1'b0;
    repeat (3) stepCycle();
    checkOutput("reset_outputs",
                32'({fifo_read, fifo_write, fifo_in, wr_ack, rd_ack, busy, timeout_err}),
                32'd0);
    reset = 1'b0;
    stepCycle();

    // Round-robin from reset: producer 0 first, then alternate.
    applyStimulus(1'b0, 2'b11, 4'h1, 4'h2, 1, mk(2'b01, 1'b0, 1'b0, 1'b1, 4'h1), 1'b0);
    applyStimulus(1'b0, 2'b11, 4'h1, 4'h2, 2, mk(2'b10, 1'b0, 1'b0, 1'b1, 4'h2), 1'b0);
    applyStimulus(1'b0, 2'b11, 4'h1, 4'h2, 1, mk(2'b01, 1'b0, 1'b0, 1'b1, 4'h1), 1'b0);
    applyStimulus(1'b0, 2'b11, 4'h1, 4'h2, 3, mk(2'b10, 1'b0, 1'b0, 1'b1, 4'h2), 1'b1);

    // Single write held three cycles before tick.
    applyStimulus(1'b0, 2'b01, 4'hA, 4'h0, 3, mk(2'b01, 1'b0, 1'b0, 1'b1, 4'hA), 1'b1);

    // Combined read+write from producer 1.
    fifo_empty = 1'b0;
    applyStimulus(1'b1, 2'b10, 4'h5, 4'h7, 2, mk(2'b10, 1'b1, 1'b1, 1'b1, 4'h7), 1'b1);
    fifo_empty = 1'b1;

    // Write blocked while full, issues right after full drops.
    fifo_full = 1'b1;
    wr_req    = 2'b01;
    wr_data0  = 4'h3;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("full_blocks", 32'({busy, fifo_write}), 32'd0);
    end
    fifo_full = 1'b0;
    applyStimulus(1'b0, 2'b01, 4'h3, 4'h0, 1, mk(2'b01, 1'b0, 1'b0, 1'b1, 4'h3), 1'b1);

    // Read blocked while empty, then a read-only command.
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("empty_blocks", 32'({busy, fifo_read}), 32'd0);
    end
    fifo_empty = 1'b0;
    applyStimulus(1'b1, 2'b00, 4'h0, 4'h0, 2, mk(2'b00, 1'b1, 1'b1, 1'b0, 4'h0), 1'b1);
    fifo_empty = 1'b1;

    // Read-only left the pointer on producer 1.
    applyStimulus(1'b0, 2'b11, 4'h1, 4'h2, 1, mk(2'b10, 1'b0, 1'b0, 1'b1, 4'h2), 1'b1);

    // Timeout: eight HOLD cycles without tick abandon the command.
    wr_req   = 2'b01;
    wr_data0 = 4'h9;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput("to_hold", 32'({busy, fifo_write, fifo_in}), 32'({1'b1, 1'b1, 4'h9}));
    end
    stepCycle();
    checkOutput("to_abort", 32'({busy, fifo_write, fifo_in, wr_ack}), 32'd0);
    checkOutput("to_err_set", 32'(timeout_err), 32'd1);
    applyStimulus(1'b0, 2'b01, 4'h9, 4'h0, 2, mk(2'b01, 1'b0, 1'b0, 1'b1, 4'h9), 1'b1);
    checkOutput("to_err_sticky", 32'(timeout_err), 32'd1);

    // Reset coincident with tick during HOLD: no ack, pointer back to 0.
    wr_req   = 2'b11;
    wr_data0 = 4'h4;
    wr_data1 = 4'h5;
    stepCycle();
    checkOutput("pre_reset_hold", 32'({busy, fifo_write, fifo_in}), 32'({1'b1, 1'b1, 4'h5}));
    reset = 1'b1;
    tick  = 1'b1;
    stepCycle();
    reset  = 1'b0;
    tick   = 1'b0;
    wr_req = 2'b00;
    checkOutput("mid_reset_outputs",
                32'({fifo_read, fifo_write, fifo_in, wr_ack, rd_ack, busy, timeout_err}),
                32'd0);
    stepCycle();
    checkOutput("post_reset_quiet",
                32'({fifo_read, fifo_write, fifo_in, wr_ack, rd_ack, busy, timeout_err}),
                32'd0);
    applyStimulus(1'b0, 2'b11, 4'h1, 4'h2, 1, mk(2'b01, 1'b0, 1'b0, 1'b1, 4'h1), 1'b1);

    repeat (3) stepCycle();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_port_arbiter.md
Name: fifo_port_arbiter

Overview:
Sequencer and arbiter in front of the 4-bit synchronous FIFO. It shares the FIFO write port between two producers using round-robin, and schedules reads for one consumer. It drives the FIFO's read/write/data inputs and holds each command stable until the FIFO's slow accept strobe (`tick`). It then returns one-cycle acknowledges and guards against full/empty misuse and a stalled strobe.

Parameters:
WIDTH, 4, data width; matches FIFO width.
TIMEOUT, 32'd50000000, max clock cycles a command may wait in HOLD for `tick` before abort.
TO_BITS, 26, width of the timeout counter; must satisfy 2^TO_BITS > TIMEOUT.

Ports:
clock  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
tick  in  1  one-cycle strobe marking the clock in which the FIFO samples read/write.
wr_req  in  2  level write requests from producer 0 and producer 1; held until ack.
wr_data0  in  WIDTH  producer 0 data; stable while wr_req[0]=1.
wr_data1  in  WIDTH  producer 1 data; stable while wr_req[1]=1.
wr_ack  out  2  one-cycle pulse: that producer's word was written.
rd_req  in  1  level read request from consumer; held until ack.
rd_ack  out  1  one-cycle pulse: read executed; FIFO output register is updated.
fifo_read  out  1  to FIFO read.
fifo_write  out  1  to FIFO write.
fifo_in  out  WIDTH  to FIFO data input.
fifo_empty  in  1  FIFO empty flag.
fifo_full  in  1  FIFO full flag (asserted at DEPTH-1 entries).
busy  out  1  high in HOLD or SETTLE.
timeout_err  out  1  sticky; set on a HOLD abort, cleared only by reset.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; rr_ptr=0 (producer 0 favoured first); timeout counter=0.
- FSM states: IDLE, HOLD, SETTLE.
- IDLE, eligibility evaluated every cycle:
  - rd_ok = rd_req & ~fifo_empty.
  - wr_ok = |wr_req & ~fifo_full.
- IDLE, write winner:
  - If both producers request, the winner is the one rr_ptr points to.
  - Otherwise the winner is the single requester.
- IDLE, on rd_ok | wr_ok:
  - Register fifo_read=rd_ok and fifo_write=wr_ok.
  - Register fifo_in = winner's data, or 0 if no write.
  - Latch the winner id, go to HOLD.
  - rd_ok and wr_ok together issue the combined read+write command {1,1}.
- Requests that are not eligible (read when empty, write when full) stay pending with no ack; no command is issued for them.
- HOLD:
  - Commands stay constant and tick is watched.
  - If tick=1 in the first HOLD cycle, that tick counts (1-cycle minimum HOLD).
  - On tick: go to SETTLE; clear fifo_read, fifo_write and fifo_in on the next edge.
- SETTLE (exactly one cycle, one cycle after the FIFO command edge):
  - Pulse wr_ack[winner] if a write was issued; pulse rd_ack if a read was issued.
  - If a write was issued, update rr_ptr = ~winner.
  - Return to IDLE; flags are re-sampled there, so back-to-back commands are one per tick window minimum.
- Ack latency: from the tick cycle, ack is high on the following cycle.
- rr_ptr changes only on an issued write; a read-only command leaves it unchanged.
- Timeout:
  - The counter runs only in HOLD and clears on leaving HOLD.
  - On reaching TIMEOUT-1 without tick: deassert commands, set timeout_err, go to IDLE, give no ack; the requester stays pending.
- Requester drop: if a requester drops its req during HOLD, the command still completes. Its ack still pulses, and the requester must ignore it.
- Reset mid-HOLD or mid-SETTLE: commands drop on the next edge and no ack is produced. Reset wins over tick in the same cycle.
- Width rule: fifo_in is exactly WIDTH bits; no extension.

Decomposition:
- Shared package fifo_pkg:
  - WIDTH default.
  - FSM state encoding: IDLE=2'd0, HOLD=2'd1, SETTLE=2'd2.
  - Command encoding {read,write}: CMD_NONE, CMD_WR, CMD_RD, CMD_RW.
- One natural sub-module, rr_arb2: 2-requester round-robin pick from (req[1:0], rr_ptr) -> grant[1:0]; purely combinational. The FSM, timeout and ack logic stay in the top.

Test Plan:
- Write-only: wr_req=01, wr_data0=4'hA, FIFO not full, tick 3 cycles later -> fifo_write=1 with fifo_in=A held 3 cycles; wr_ack=01 exactly 1 cycle after tick; rr_ptr=1.
- Round-robin: wr_req=11 held for 4 ticks, data0=1, data1=2 -> write order 1,2,1,2; acks alternate 01,10,01,10.
- Combined read+write: rd_req=1, wr_req=10 (data 4'h7), fifo_empty=0 -> single command read=1 and write=1; rd_ack and wr_ack[1] pulse in the same cycle.
- Boundaries:
  - fifo_full=1 with wr_req=01 -> no fifo_write and no ack; after fifo_full drops, the write issues on the next IDLE cycle.
  - fifo_empty=1 with rd_req=1 -> no fifo_read.
- Timeout: TIMEOUT=8 override, wr_req=01, no tick -> after 8 HOLD cycles commands drop, timeout_err=1, no ack; a later tick completes a reissued write.
- Reset mid-HOLD: assert reset 1 cycle during HOLD coincident with tick -> all outputs 0 next cycle, no ack, timeout_err=0, rr_ptr=0.
